// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and the most-negative-value helper.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int MAX_N = 64;

   // 1 followed by n-1 zeros; callers truncate to their own width.
   function automatic logic [MAX_N-1:0] most_neg(input int n);
      return MAX_N'(1) << (n - 1);
   endfunction

endpackage

// File: rtl/muldiv_abs_neg.sv
// Combinational N-bit conditional two's-complement negate, used both to take
// operand magnitudes and to sign-correct results.
module muldiv_abs_neg #(
   parameter int N = 32
) (
   input  logic [N-1:0] din,
   input  logic         neg,
   output logic [N-1:0] dout
);

   assign dout = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the EX stage; one shared
// shift-add / restoring-divide datapath. Optional early-out: MULDIV_EARLY_OUT_EN.
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [2:0]   op_i,
   input  logic [N-1:0] rs1_i,
   input  logic [N-1:0] rs2_i,
   input  logic         flush_i,
   output logic [N-1:0] result_o,
   output logic         done_o,
   output logic         busy_o,
   output logic         stall_o
);

   localparam int CW = $clog2(N);

   state_t         state_reg, state_next;
   logic [CW-1:0]  cnt_reg;
   logic [2:0]     op_reg;
   logic [N-1:0]   hi_reg;      // product high half / partial remainder
   logic [N-1:0]   lo_reg;      // product low half / dividend shifting into quotient
   logic [N-1:0]   b_reg;       // multiplicand / divisor magnitude
   logic           res_neg_reg; // product or quotient must be negated
   logic           rem_neg_reg; // remainder must be negated
   logic [N-1:0]   result_reg;

   // ---------------- operand decode and magnitudes ----------------
   logic         a_signed, b_signed, a_neg, b_neg;
   logic         is_div_in, div_zero, accept;
   logic [N-1:0] a_mag, b_mag;

   assign a_signed  = (op_i == OP_MULH) | (op_i == OP_MULHSU) |
                      (op_i == OP_DIV)  | (op_i == OP_REM);
   assign b_signed  = (op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM);
   assign a_neg     = a_signed & rs1_i[N-1];
   assign b_neg     = b_signed & rs2_i[N-1];
   assign is_div_in = op_i[2];
   assign div_zero  = is_div_in & (rs2_i == '0);
   assign accept    = (state_reg == IDLE) & start_i & ~flush_i;

   muldiv_abs_neg #(.N(N)) u_abs_a (.din(rs1_i), .neg(a_neg), .dout(a_mag));
   muldiv_abs_neg #(.N(N)) u_abs_b (.din(rs2_i), .neg(b_neg), .dout(b_mag));

   // Values loaded into hi/lo when an op is accepted. Early-out cases preload
   // the final unsigned hi/lo pair so FIX can sign-correct it unchanged.
   logic         skip_calc;
   logic [N-1:0] load_hi, load_lo;

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic [N-1:0] MOST_NEG = N'(most_neg(N));
   logic div_ovf, mul_zero, div_small;

   assign div_ovf   = ((op_i == OP_DIV) | (op_i == OP_REM)) &
                      (rs1_i == MOST_NEG) & (rs2_i == '1);
   assign mul_zero  = ~is_div_in & ((rs1_i == '0) | (rs2_i == '0));
   assign div_small = is_div_in & (a_mag < b_mag);

   always_comb begin
      skip_calc = 1'b0;
      load_hi   = '0;
      load_lo   = a_mag;
      if (div_zero) begin
         skip_calc = 1'b1;
         load_hi   = a_mag;
         load_lo   = '1;
      end else if (div_ovf) begin
         skip_calc = 1'b1;
         load_lo   = a_mag;
      end else if (mul_zero) begin
         skip_calc = 1'b1;
         load_lo   = '0;
      end else if (div_small) begin
         skip_calc = 1'b1;
         load_hi   = a_mag;
         load_lo   = '0;
      end
   end
`else
   always_comb begin
      skip_calc = 1'b0;
      load_hi   = '0;
      load_lo   = a_mag;
   end
`endif

   // ---------------- one iteration of the shared datapath ----------------
   logic [N:0]   mul_sum, div_trial;
   logic         div_ok;
   logic [N-1:0] iter_hi, iter_lo;

   always_comb begin
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
      div_trial = {hi_reg, lo_reg[N-1]} - {1'b0, b_reg};
      div_ok    = ~div_trial[N];
      if (op_reg[2]) begin
         iter_hi = div_ok ? div_trial[N-1:0] : {hi_reg[N-2:0], lo_reg[N-1]};
         iter_lo = {lo_reg[N-2:0], div_ok};
      end else begin
         iter_hi = mul_sum[N:1];
         iter_lo = {mul_sum[0], lo_reg[N-1:1]};
      end
   end

   // ---------------- sign fix and result select ----------------
   // A 2N-bit negate borrows into the high half only when the low half is 0;
   // otherwise the high half is just inverted.
   logic         lo_zero, hi_neg_en, hi_inv, sel_lo;
   logic [N-1:0] lo_fix, hi_fix, fix_value;

   assign lo_zero   = (lo_reg == '0);
   assign hi_neg_en = op_reg[2] ? rem_neg_reg : (res_neg_reg & lo_zero);
   assign hi_inv    = ~op_reg[2] & res_neg_reg & ~lo_zero;
   assign sel_lo    = (op_reg == OP_MUL) | (op_reg == OP_DIV) | (op_reg == OP_DIVU);

   muldiv_abs_neg #(.N(N)) u_fix_lo (.din(lo_reg), .neg(res_neg_reg), .dout(lo_fix));
   muldiv_abs_neg #(.N(N)) u_fix_hi (.din(hi_reg), .neg(hi_neg_en),   .dout(hi_fix));

   assign fix_value = sel_lo ? lo_fix : (hi_inv ? ~hi_reg : hi_fix);

   // ---------------- FSM ----------------
   always_comb begin
      state_next = state_reg;
      done_o     = 1'b0;
      busy_o     = (state_reg != IDLE);
      stall_o    = 1'b0;
      case (state_reg)
         IDLE: begin
            stall_o = rst_n & accept;
            if (accept) state_next = skip_calc ? FIX : CALC;
         end
         CALC: begin
            stall_o = rst_n;
            if (cnt_reg == CW'(N - 1)) state_next = FIX;
         end
         FIX: begin
            stall_o    = rst_n;
            state_next = DONE;
         end
         DONE: begin
            done_o     = ~flush_i;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (flush_i) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         op_reg      <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         b_reg       <= '0;
         res_neg_reg <= 1'b0;
         rem_neg_reg <= 1'b0;
         result_reg  <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_reg      <= op_i;
                  b_reg       <= b_mag;
                  cnt_reg     <= '0;
                  hi_reg      <= load_hi;
                  lo_reg      <= load_lo;
                  // Divide-by-zero quotient is all ones whatever the signs.
                  res_neg_reg <= (a_neg ^ b_neg) & ~div_zero;
                  rem_neg_reg <= a_neg;
               end
            end
            CALC: begin
               cnt_reg <= cnt_reg + CW'(1);
               hi_reg  <= iter_hi;
               lo_reg  <= iter_lo;
            end
            FIX: begin
               if (!flush_i) result_reg <= fix_value;
            end
            default: ;
         endcase
      end
   end

   assign result_o = result_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (N=32): results, latency,
// stall window, divide corner cases, flush, held start and mid-op reset.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        flush_i;
   logic [31:0] result_o;
   logic        done_o;
   logic        busy_o;
   logic        stall_o;

   int tests = 0;
   int fails = 0;

   localparam int LIMIT = 60;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_EARLY = 2;
`else
   localparam int LAT_EARLY = 34;
`endif

   ex_muldiv_unit #(.N(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .op_i     (op_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .flush_i  (flush_i),
      .result_o (result_o),
      .done_o   (done_o),
      .busy_o   (busy_o),
      .stall_o  (stall_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Cycle 0 is the cycle in which start_i is presented; done_cyc is the
   // cycle index in which done_o is seen (-1 if never within LIMIT).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int done_cyc, output logic [31:0] res,
                         output int stall_cnt, output int done_cnt, output logic stall_at_done);
      done_cyc = -1; res = '0; stall_cnt = 0; done_cnt = 0; stall_at_done = 1'bx;
      @(negedge clk);
      start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
      #1;
      if (stall_o) stall_cnt++;
      for (int c = 1; c <= LIMIT; c++) begin
         @(negedge clk);
         if (!hold) start_i = 1'b0;
         #1;
         if (stall_o) stall_cnt++;
         if (done_o) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc      = c;
               res           = result_o;
               stall_at_done = stall_o;
            end
            start_i = 1'b0;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
      start_i = 1'b0;
   endtask

   int          dc, sc, dn;
   logic [31:0] r;
   logic        sd;
   int          flush_done;

   initial begin
      rst_n = 1'b0; start_i = 1'b0; op_i = 3'b000; rs1_i = '0; rs2_i = '0; flush_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset result_o", result_o, 32'h0);
      chk("reset done_o",   {31'b0, done_o},  32'h0);
      chk("reset busy_o",   {31'b0, busy_o},  32'h0);
      chk("reset stall_o",  {31'b0, stall_o}, 32'h0);
      rst_n = 1'b1;

      run_op(3'b000, 32'd7, 32'hFFFFFFFD, 1'b0, dc, r, sc, dn, sd);
      chk("MUL result",        r, 32'hFFFFFFEB);
      chk("MUL done cycle",    dc, 34);
      chk("MUL stall cycles",  sc, 34);
      chk("MUL stall at done", {31'b0, sd}, 32'h0);
      chk("MUL done pulses",   dn, 1);

      run_op(3'b001, 32'h80000000, 32'h80000000, 1'b0, dc, r, sc, dn, sd);
      chk("MULH result", r, 32'h40000000);
      run_op(3'b010, 32'hFFFFFFFF, 32'h00000002, 1'b0, dc, r, sc, dn, sd);
      chk("MULHSU result", r, 32'hFFFFFFFF);

      run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, dc, r, sc, dn, sd);
      chk("MULHU held result", r, 32'hFFFFFFFE);
      chk("MULHU held pulses", dn, 1);
      chk("MULHU held done cycle", dc, 34);

      run_op(3'b100, 32'hFFFFFFF9, 32'd2, 1'b0, dc, r, sc, dn, sd);
      chk("DIV -7/2", r, 32'hFFFFFFFD);
      run_op(3'b110, 32'hFFFFFFF9, 32'd2, 1'b0, dc, r, sc, dn, sd);
      chk("REM -7/2", r, 32'hFFFFFFFF);
      run_op(3'b101, 32'd100, 32'd7, 1'b0, dc, r, sc, dn, sd);
      chk("DIVU 100/7", r, 32'd14);
      chk("DIVU done cycle", dc, 34);
      run_op(3'b111, 32'd100, 32'd7, 1'b0, dc, r, sc, dn, sd);
      chk("REMU 100/7", r, 32'd2);

      run_op(3'b100, 32'd5, 32'd0, 1'b0, dc, r, sc, dn, sd);
      chk("DIV 5/0", r, 32'hFFFFFFFF);
      chk("DIV 5/0 done cycle", dc, LAT_EARLY);
      run_op(3'b110, 32'd5, 32'd0, 1'b0, dc, r, sc, dn, sd);
      chk("REM 5/0", r, 32'd5);
      chk("REM 5/0 done cycle", dc, LAT_EARLY);
      run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b0, dc, r, sc, dn, sd);
      chk("DIV overflow", r, 32'h80000000);
      chk("DIV overflow done cycle", dc, LAT_EARLY);
      run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b0, dc, r, sc, dn, sd);
      chk("REM overflow", r, 32'h0);
      chk("REM overflow done cycle", dc, LAT_EARLY);

      // Flush a DIV in cycle 10; nothing may complete, then a MUL runs cleanly.
      flush_done = 0;
      @(negedge clk);
      start_i = 1'b1; op_i = 3'b100; rs1_i = 32'd1000; rs2_i = 32'd3;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         #1;
         if (done_o) flush_done++;
      end
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      chk("flush busy_o next cycle", {31'b0, busy_o}, 32'h0);
      if (done_o) flush_done++;
      chk("flush no done_o", flush_done, 0);
      run_op(3'b000, 32'd12345, 32'd678, 1'b0, dc, r, sc, dn, sd);
      chk("MUL after flush", r, 32'd8369910);
      chk("MUL after flush done cycle", dc, 34);

      // Reset in the middle of CALC.
      @(negedge clk);
      start_i = 1'b1; op_i = 3'b101; rs1_i = 32'd999; rs2_i = 32'd10;
      repeat (5) @(negedge clk);
      start_i = 1'b0;
      rst_n   = 1'b0;
      @(negedge clk);
      #1;
      chk("mid reset result_o", result_o, 32'h0);
      chk("mid reset done_o",   {31'b0, done_o},  32'h0);
      chk("mid reset busy_o",   {31'b0, busy_o},  32'h0);
      chk("mid reset stall_o",  {31'b0, stall_o}, 32'h0);
      rst_n = 1'b1;
      run_op(3'b101, 32'd999, 32'd10, 1'b0, dc, r, sc, dn, sd);
      chk("DIVU after reset", r, 32'd99);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the forwarded operands produced by the EX operand-select muxes (rs1/rs2 after forwarding) and returns a result to the EX/MEM write-back path.
- Holds the pipeline with a stall request while it iterates.
- One radix-2 shift-add / restoring-divide datapath is shared by all eight M-extension ops.

Parameters:
- N, 32, operand and result width in bits; must be even and at least 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start_i  input  1  EX holds a valid M-extension instruction
- op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  input  N  forwarded operand A (multiplicand or dividend)
- rs2_i  input  N  forwarded operand B (multiplier or divisor)
- flush_i  input  1  kill the in-flight op (branch mispredict or trap)
- result_o  output  N  registered result
- done_o  output  1  one-cycle pulse; result_o is valid this cycle
- busy_o  output  1  unit not in IDLE
- stall_o  output  1  stall request to the hazard unit

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset: state goes to IDLE. result_o=0, done_o=0, busy_o=0, stall_o=0, and all internal registers clear.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start_i=1 and flush_i=0, capture op_i, the operand magnitudes and the sign flags.
  - Load iteration counter = 0 and go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Performs one iteration per cycle for N cycles on unsigned magnitudes.
  - Multiply: 2N-bit shift-add.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Moves to FIX after the counter reaches N-1.
- FIX (1 cycle):
  - Sign-correct the result and select the output: low N bits for MUL, high N bits for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register the value into result_o.
- DONE (1 cycle): done_o=1, then go to IDLE. start_i is ignored in DONE because the same instruction is still present.
- Latency: start accepted in cycle 0 gives done_o in cycle N+2 (34 for N=32).
- stall_o = (state==IDLE & start_i & ~flush_i) | state==CALC | state==FIX.
  - stall_o is low in DONE so the pipeline advances and captures result_o.
- busy_o = state != IDLE.
- result_o holds its last value until the next FIX.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both operands signed.
  - The quotient is negative when the operand signs differ. The remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = rs1. No exception is raised.
- Signed overflow (rs1 = 1 followed by N-1 zeros, rs2 = -1): quotient = rs1, remainder = 0.
- flush_i=1 in any state: next state is IDLE and done_o stays 0. Flush has priority over start_i.
- Reset mid-op: aborts immediately with no done_o.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, the following cases skip CALC and go straight to FIX, so done_o arrives in cycle 2:
  - divide by zero
  - signed overflow
  - either multiply operand zero
  - dividend magnitude < divisor magnitude (quotient 0, remainder rs1)
- Not defined: latency is always N+2 and the early-out logic is absent.

Decomposition:
- Package muldiv_pkg:
  - funct3 op localparams (OP_MUL .. OP_REMU)
  - state encoding (IDLE, CALC, FIX, DONE)
  - helper constant for the most-negative value
- One natural sub-module: muldiv_abs_neg. It is combinational N-bit conditional two's-complement negate and is instantiated for operand magnitude and for result sign fix.
- The counter and FSM stay in the top module.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result_o=0xFFFFFFEB; done_o exactly in cycle 34; stall_o high in cycles 0-33, low in 34.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0. With MULDIV_EARLY_OUT_EN, done_o for these arrives in cycle 2.
- flush_i in cycle 10 of a DIV -> busy_o=0 next cycle and no done_o; a new MUL started the following cycle completes correctly.
- start_i held high through DONE -> only one done_o pulse. rst_n=0 mid-CALC -> all outputs 0 the next cycle.
